// File: rtl/cpu_sb_pkg.sv
// Shared widths and types for the CPU register-write scoreboard.
package cpu_sb_pkg;

   localparam int unsigned NUM_REGS = 16;
   localparam int unsigned REG_W    = 4;
   localparam int unsigned CNT_W    = 2;
   localparam int unsigned JB_W     = 2;
   localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

   typedef logic [CNT_W-1:0] sb_cnt_t;
   typedef logic [REG_W-1:0] sb_reg_t;

endpackage : cpu_sb_pkg

// File: rtl/cpu_sb_entry.sv
// One saturating up/down in-flight counter. A simultaneous inc and dec leaves
// the count unchanged. A step past either end holds the count and pulses err_o.
module cpu_sb_entry
   import cpu_sb_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic busy_o,
   output logic err_o
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] cnt_q, cnt_d;

   // Next count with saturation; err_o flags the blocked step.
   always_comb begin
      cnt_d = cnt_q;
      err_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q == MAX) err_o = 1'b1;
         else              cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0)  err_o = 1'b1;
         else              cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register; reset clears it.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign busy_o = |cnt_q;

endmodule : cpu_sb_entry

// File: rtl/cpu_scoreboard.sv
// Register-write scoreboard: per-register in-flight counts, a busy vector,
// a fetch-side read-after-write stall and a jump/branch-outstanding stall.
// Optional feature macro: SB_PERF_EN enables the two 32-bit stall counters.
module cpu_scoreboard
   import cpu_sb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_vld,
   input  logic                issue_wrt_en,
   input  logic [REG_W-1:0]    issue_wrt_reg,
   input  logic                issue_jb,
   input  logic                rel_vld,
   input  logic [REG_W-1:0]    rel_wrt_reg,
   input  logic                jb_resolve,
   input  logic                src_a_vld,
   input  logic                src_b_vld,
   input  logic [REG_W-1:0]    src_a,
   input  logic [REG_W-1:0]    src_b,
   output logic [NUM_REGS-1:0] busy,
   output logic                rd_wrt_stall,
   output logic                jb_stall,
   output logic                sb_err,
   output logic [31:0]         stall_cycles,
   output logic [31:0]         jb_stall_cycles
);

   logic [NUM_REGS-1:0] inc_v, dec_v, busy_v, err_v;
   logic                jb_err;
   logic                err_q, err_d;

   // One-hot decode of the issue and release destinations.
   always_comb begin
      inc_v = '0;
      dec_v = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         inc_v[i] = issue_vld & issue_wrt_en & (issue_wrt_reg == REG_W'(i));
         dec_v[i] = rel_vld & (rel_wrt_reg == REG_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
      cpu_sb_entry #(.W(CNT_W)) u_entry (
         .clk_i  (clk),
         .rst_i  (rst),
         .inc_i  (inc_v[g]),
         .dec_i  (dec_v[g]),
         .busy_o (busy_v[g]),
         .err_o  (err_v[g])
      );
   end

   cpu_sb_entry #(.W(JB_W)) u_jb (
      .clk_i  (clk),
      .rst_i  (rst),
      .inc_i  (issue_vld & issue_jb),
      .dec_i  (jb_resolve),
      .busy_o (jb_stall),
      .err_o  (jb_err)
   );

   // Sticky error accumulates any saturation event until reset.
   always_comb begin
      err_d = err_q | (|err_v) | jb_err;
   end

   // Sticky error register; reset wins over same-cycle saturation.
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign busy         = busy_v;
   assign sb_err       = err_q;
   // No bypass: a same-cycle release does not clear the stall.
   assign rd_wrt_stall = (src_a_vld & busy_v[src_a]) | (src_b_vld & busy_v[src_b]);

`ifdef SB_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] jb_cnt_q, jb_cnt_d;

   // Stall-cycle counters advance after each stalled cycle and wrap.
   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, rd_wrt_stall};
      jb_cnt_d    = jb_cnt_q + {31'd0, jb_stall};
   end

   // Perf counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         jb_cnt_q    <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         jb_cnt_q    <= jb_cnt_d;
      end
   end

   assign stall_cycles    = stall_cnt_q;
   assign jb_stall_cycles = jb_cnt_q;
`else
   assign stall_cycles    = '0;
   assign jb_stall_cycles = '0;
`endif

endmodule : cpu_scoreboard

// File: tb/tb_cpu_scoreboard.sv
// Self-checking bench for cpu_scoreboard: directed scenarios plus a random
// run compared against a counts-per-register reference model.
module tb_cpu_scoreboard;

   logic        clk = 1'b0;
   logic        rst, issue_vld, issue_wrt_en, issue_jb, rel_vld, jb_resolve;
   logic        src_a_vld, src_b_vld;
   logic [3:0]  issue_wrt_reg, rel_wrt_reg, src_a, src_b;
   logic [15:0] busy;
   logic        rd_wrt_stall, jb_stall, sb_err;
   logic [31:0] stall_cycles, jb_stall_cycles;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_cnt [16];
   int          m_jb;
   bit          m_err;
   int unsigned m_sc, m_jsc;

   always #5 clk = ~clk;

   cpu_scoreboard dut (
      .clk(clk), .rst(rst),
      .issue_vld(issue_vld), .issue_wrt_en(issue_wrt_en), .issue_wrt_reg(issue_wrt_reg),
      .issue_jb(issue_jb), .rel_vld(rel_vld), .rel_wrt_reg(rel_wrt_reg),
      .jb_resolve(jb_resolve), .src_a_vld(src_a_vld), .src_b_vld(src_b_vld),
      .src_a(src_a), .src_b(src_b), .busy(busy), .rd_wrt_stall(rd_wrt_stall),
      .jb_stall(jb_stall), .sb_err(sb_err), .stall_cycles(stall_cycles),
      .jb_stall_cycles(jb_stall_cycles)
   );

   function automatic logic [15:0] m_busy();
      logic [15:0] b;
      for (int i = 0; i < 16; i++) b[i] = (m_cnt[i] != 0);
      return b;
   endfunction

   function automatic bit m_stall();
      return (src_a_vld && m_cnt[src_a] != 0) || (src_b_vld && m_cnt[src_b] != 0);
   endfunction

   function automatic logic [31:0] exp_perf(input int unsigned v);
`ifdef SB_PERF_EN
      return v;
`else
      return (v == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   // Advance one clock and apply the architectural rules to the model.
   task automatic tick();
      bit st, jst, inc, dec;
      st  = m_stall();
      jst = (m_jb != 0);
      @(posedge clk);
      if (rst) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_jb = 0; m_err = 0; m_sc = 0; m_jsc = 0;
      end else begin
         for (int r = 0; r < 16; r++) begin
            inc = issue_vld && issue_wrt_en && (issue_wrt_reg == 4'(r));
            dec = rel_vld && (rel_wrt_reg == 4'(r));
            if (inc && !dec) begin
               if (m_cnt[r] == 3) m_err = 1; else m_cnt[r]++;
            end else if (dec && !inc) begin
               if (m_cnt[r] == 0) m_err = 1; else m_cnt[r]--;
            end
         end
         inc = issue_vld && issue_jb;
         dec = jb_resolve;
         if (inc && !dec) begin
            if (m_jb == 3) m_err = 1; else m_jb++;
         end else if (dec && !inc) begin
            if (m_jb == 0) m_err = 1; else m_jb--;
         end
         m_sc  += st;
         m_jsc += jst;
      end
      #1;
   endtask

   task automatic clear_inputs();
      issue_vld = 0; issue_wrt_en = 0; issue_wrt_reg = 0; issue_jb = 0;
      rel_vld = 0; rel_wrt_reg = 0; jb_resolve = 0;
      src_a_vld = 0; src_b_vld = 0; src_a = 0; src_b = 0;
   endtask

   task automatic do_reset();
      rst = 1; clear_inputs(); tick(); rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      src_a_vld = 1; src_a = 4'($urandom_range(0, 15));
      src_b_vld = 1; src_b = 4'($urandom_range(0, 15));
      #1;
      checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, 16'h0); end
      checks++; if (rd_wrt_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", rd_wrt_stall); end
      checks++; if (jb_stall !== 1'b0) begin errors++; $display("FAIL reset_jb_stall: got %b expected 0", jb_stall); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sb_err); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d expected 0", stall_cycles); end
      clear_inputs();
   endtask

   task automatic test_raw_stall();
      do_reset();
      issue_vld = 1; issue_wrt_en = 1; issue_wrt_reg = 3;
      src_a_vld = 1; src_a = 3;
      tick();
      checks++; if (busy !== 16'h0008) begin errors++; $display("FAIL raw_busy: got %h expected %h", busy, 16'h0008); end
      checks++; if (rd_wrt_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_set: got %b expected 1", rd_wrt_stall); end
      issue_vld = 0; issue_wrt_en = 0;
      tick(); tick(); tick();
      rel_vld = 1; rel_wrt_reg = 3;
      #1;
      checks++; if (rd_wrt_stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass: got %b expected 1", rd_wrt_stall); end
      tick();
      rel_vld = 0;
      checks++; if (busy !== 16'h0) begin errors++; $display("FAIL raw_release_busy: got %h expected %h", busy, 16'h0); end
      checks++; if (rd_wrt_stall !== 1'b0) begin errors++; $display("FAIL raw_stall_clear: got %b expected 0", rd_wrt_stall); end
      clear_inputs();
   endtask

   task automatic test_saturation();
      do_reset();
      issue_vld = 1; issue_wrt_en = 1; issue_wrt_reg = 5;
      tick(); tick(); tick();
      rel_vld = 1; rel_wrt_reg = 5;
      tick();
      rel_vld = 0;
      checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL sat_busy: got %h expected %h", busy, 16'h0020); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL sat_no_err: got %b expected 0", sb_err); end
      tick();
      issue_vld = 0; issue_wrt_en = 0;
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sat_overflow_err: got %b expected 1", sb_err); end
      rel_vld = 1; rel_wrt_reg = 5;
      tick(); tick();
      checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL sat_held_at_max: got %h expected %h", busy, 16'h0020); end
      tick();
      rel_vld = 0;
      checks++; if (busy !== 16'h0) begin errors++; $display("FAIL sat_drained: got %h expected %h", busy, 16'h0); end
      tick(); tick();
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", sb_err); end
      clear_inputs();
   endtask

   task automatic test_underflow();
      do_reset();
      rel_vld = 1; rel_wrt_reg = 7;
      tick();
      rel_vld = 0;
      checks++; if (busy !== 16'h0) begin errors++; $display("FAIL under_busy: got %h expected %h", busy, 16'h0); end
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL under_err: got %b expected 1", sb_err); end
      issue_vld = 1; issue_wrt_en = 1; issue_wrt_reg = 7;
      tick();
      issue_vld = 0; issue_wrt_en = 0;
      checks++; if (busy !== 16'h0080) begin errors++; $display("FAIL under_held_zero: got %h expected %h", busy, 16'h0080); end
      clear_inputs();
   endtask

   task automatic test_jb();
      logic exp [4];
      exp[0] = 1; exp[1] = 1; exp[2] = 1; exp[3] = 0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         issue_vld  = (c < 2);
         issue_jb   = (c < 2);
         jb_resolve = (c == 1 || c == 3);
         tick();
         checks++;
         if (jb_stall !== exp[c]) begin
            errors++; $display("FAIL jb_stall_c%0d: got %b expected %b", c + 1, jb_stall, exp[c]);
         end
      end
      clear_inputs();
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL jb_no_err: got %b expected 0", sb_err); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int r = 4; r < 8; r++) begin
         issue_vld = 1; issue_wrt_en = 1; issue_wrt_reg = 4'(r);
         issue_jb = (r < 6);
         tick();
      end
      clear_inputs();
      checks++; if (busy !== 16'h00F0) begin errors++; $display("FAIL mid_pre_busy: got %h expected %h", busy, 16'h00F0); end
      checks++; if (jb_stall !== 1'b1) begin errors++; $display("FAIL mid_pre_jb: got %b expected 1", jb_stall); end
      rst = 1; issue_vld = 1; issue_wrt_en = 1; issue_wrt_reg = 2; issue_jb = 1;
      rel_vld = 1; rel_wrt_reg = 0;
      tick();
      rst = 0; clear_inputs();
      src_a_vld = 1; src_a = 4; src_b_vld = 1; src_b = 2;
      #1;
      checks++; if (busy !== 16'h0) begin errors++; $display("FAIL mid_busy: got %h expected %h", busy, 16'h0); end
      checks++; if (jb_stall !== 1'b0) begin errors++; $display("FAIL mid_jb: got %b expected 0", jb_stall); end
      checks++; if (rd_wrt_stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b expected 0", rd_wrt_stall); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", sb_err); end
      clear_inputs();
   endtask

   task automatic test_perf();
      do_reset();
      issue_vld = 1; issue_wrt_en = 1; issue_wrt_reg = 2;
      tick();
      issue_vld = 0; issue_wrt_en = 0;
      src_a_vld = 1; src_a = 2;
      repeat (10) tick();
      src_a_vld = 0;
      tick();
      checks++;
      if (stall_cycles !== exp_perf(10)) begin
         errors++; $display("FAIL perf_stall_cycles: got %0d expected %0d", stall_cycles, exp_perf(10));
      end
      checks++;
      if (jb_stall_cycles !== 32'd0) begin
         errors++; $display("FAIL perf_jb_cycles: got %0d expected 0", jb_stall_cycles);
      end
      clear_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst           = ($urandom_range(0, 63) == 0);
         issue_vld     = 1'($urandom);
         issue_wrt_en  = 1'($urandom);
         issue_wrt_reg = 4'($urandom_range(0, 3));
         issue_jb      = ($urandom_range(0, 3) == 0);
         rel_vld       = 1'($urandom);
         rel_wrt_reg   = 4'($urandom_range(0, 3));
         jb_resolve    = ($urandom_range(0, 3) == 0);
         src_a_vld     = 1'($urandom);
         src_b_vld     = 1'($urandom);
         src_a         = 4'($urandom_range(0, 5));
         src_b         = 4'($urandom_range(0, 5));
         #1;
         checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rand_busy @%0d: got %h expected %h", n, busy, m_busy()); end
         checks++; if (rd_wrt_stall !== m_stall()) begin errors++; $display("FAIL rand_stall @%0d: got %b expected %b", n, rd_wrt_stall, m_stall()); end
         checks++; if (jb_stall !== (m_jb != 0)) begin errors++; $display("FAIL rand_jb @%0d: got %b expected %b", n, jb_stall, (m_jb != 0)); end
         checks++; if (sb_err !== m_err) begin errors++; $display("FAIL rand_err @%0d: got %b expected %b", n, sb_err, m_err); end
         checks++; if (stall_cycles !== exp_perf(m_sc)) begin errors++; $display("FAIL rand_perf @%0d: got %0d expected %0d", n, stall_cycles, exp_perf(m_sc)); end
         checks++; if (jb_stall_cycles !== exp_perf(m_jsc)) begin errors++; $display("FAIL rand_jb_perf @%0d: got %0d expected %0d", n, jb_stall_cycles, exp_perf(m_jsc)); end
         tick();
      end
      rst = 0;
      clear_inputs();
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_jb = 0; m_err = 0; m_sc = 0; m_jsc = 0;
      @(negedge clk);
      test_reset();
      test_raw_stall();
      test_saturation();
      test_underflow();
      test_jb();
      test_mid_reset();
      test_perf();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_cpu_scoreboard
